// File: rtl/rom_port_arbiter.sv
// Two-port arbiter for the shared combinational instruction ROM read port.
// Optional address/alignment checking is built when ROM_ALIGN_CHECK_EN is defined.
module rom_port_arbiter #(
   parameter int unsigned ROM_SIZE     = 256,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [30:0]      req0_addr,
   output logic             req0_ready,
   output logic             rsp0_valid,
   output logic [31:0]      rsp0_data,
   output logic             rsp0_err,
   input  logic             req1_valid,
   input  logic [30:0]      req1_addr,
   output logic             req1_ready,
   output logic             rsp1_valid,
   output logic [31:0]      rsp1_data,
   output logic             rsp1_err,
   output logic [30:0]      rom_addr,
   input  logic [31:0]      rom_data,
   output logic [CNT_W-1:0] starve_cnt
);

   localparam int unsigned WORD_W = 29;
   localparam int unsigned DATA_W = 32;

   logic             force_grant;
   logic             grant0;
   logic             grant1;
   logic [CNT_W-1:0] cnt_next;
   logic             range_err;
   logic             addr_err;
   logic [DATA_W-1:0] rd_data;

   // Port 0 wins unless port 1 has waited STARVE_LIMIT cycles
   always_comb begin
      force_grant = (starve_cnt == CNT_W'(STARVE_LIMIT));
      grant1      = req1_valid & (~req0_valid | force_grant);
      grant0      = req0_valid & ~grant1;
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Port 0 address is the default so the fetch path sees no extra select when idle
   assign rom_addr = grant1 ? req1_addr : req0_addr;

   assign range_err = (rom_addr[30:2] >= WORD_W'(ROM_SIZE));

`ifdef ROM_ALIGN_CHECK_EN
   assign addr_err = range_err | (rom_addr[1:0] != 2'b00);
`else
   assign addr_err = 1'b0;
`endif

   // Out-of-range words read as zero, as the ROM itself returns
   assign rd_data = (range_err | addr_err) ? '0 : rom_data;

   always_comb begin
      cnt_next = starve_cnt;
      if (!req1_valid || grant1) begin
         cnt_next = '0;
      end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
         cnt_next = starve_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp1_data  <= '0;
         starve_cnt <= '0;
      end else begin
         rsp0_valid <= grant0;
         rsp1_valid <= grant1;
         starve_cnt <= cnt_next;
         if (grant0) rsp0_data <= rd_data;
         if (grant1) rsp1_data <= rd_data;
      end
   end

`ifdef ROM_ALIGN_CHECK_EN
   // Error flags travel with the data they qualify
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp0_err <= 1'b0;
         rsp1_err <= 1'b0;
      end else begin
         if (grant0) rsp0_err <= addr_err;
         if (grant1) rsp1_err <= addr_err;
      end
   end
`else
   assign rsp0_err = 1'b0;
   assign rsp1_err = 1'b0;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter with a behavioural ROM (word i = 0xA5000000 + i).
module tb_rom_port_arbiter;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             req0_valid;
   logic [30:0]      req0_addr;
   logic             req0_ready;
   logic             rsp0_valid;
   logic [31:0]      rsp0_data;
   logic             rsp0_err;
   logic             req1_valid;
   logic [30:0]      req1_addr;
   logic             req1_ready;
   logic             rsp1_valid;
   logic [31:0]      rsp1_data;
   logic             rsp1_err;
   logic [30:0]      rom_addr;
   logic [31:0]      rom_data;
   logic [CNT_W-1:0] starve_cnt;

   int total = 0;
   int bad   = 0;

   rom_port_arbiter #(.ROM_SIZE(256), .STARVE_LIMIT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
      .rom_addr(rom_addr), .rom_data(rom_data), .starve_cnt(starve_cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      if (rom_addr[30:2] < 29'd256) rom_data = 32'hA500_0000 + 32'(rom_addr[30:2]);
      else                          rom_data = 32'h0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int p0_grants;
      logic exp_r1;

      reset = 1'b1;
      req0_valid = 1'b0; req0_addr = '0;
      req1_valid = 1'b0; req1_addr = '0;
      #1;
      chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("rst_rsp0_data", rsp0_data, 32'd0);
      chk("rst_rsp1_data", rsp1_data, 32'd0);
      chk("rst_err", 32'({rsp0_err, rsp1_err}), 32'd0);
      chk("rst_cnt", 32'(starve_cnt), 32'd0);
      tick();
      tick();
      reset = 1'b0;

      // port 0 alone
      req0_valid = 1'b1; req0_addr = 31'h8;
      #1;
      chk("p0_ready", 32'(req0_ready), 32'd1);
      chk("p0_r1_ready", 32'(req1_ready), 32'd0);
      chk("p0_rom_addr", 32'(rom_addr), 32'h8);
      tick();
      chk("p0_rsp_valid", 32'(rsp0_valid), 32'd1);
      chk("p0_rsp_data", rsp0_data, 32'hA500_0002);
      chk("p0_rsp1_valid", 32'(rsp1_valid), 32'd0);
      req0_valid = 1'b0; req0_addr = 31'h40;
      tick();
      chk("p0_idle_valid", 32'(rsp0_valid), 32'd0);
      chk("p0_data_hold", rsp0_data, 32'hA500_0002);

      // port 1 alone
      req1_valid = 1'b1; req1_addr = 31'h3FC;
      #1;
      chk("p1_ready", 32'(req1_ready), 32'd1);
      chk("p1_rom_addr", 32'(rom_addr), 32'h3FC);
      tick();
      chk("p1_rsp_valid", 32'(rsp1_valid), 32'd1);
      chk("p1_rsp_data", rsp1_data, 32'hA500_00FF);
      chk("p1_rsp0_valid", 32'(rsp0_valid), 32'd0);

      // both requesting continuously: port 1 every fifth cycle
      req0_valid = 1'b1; req0_addr = 31'h20;
      req1_valid = 1'b1; req1_addr = 31'h10;
      p0_grants = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         exp_r1 = ((i % 5) == 4);
         chk("both_cnt", 32'(starve_cnt), 32'(i % 5));
         chk("both_r1", 32'(req1_ready), 32'(exp_r1));
         chk("both_r0", 32'(req0_ready), 32'(!exp_r1));
         if (req0_ready) p0_grants++;
         tick();
         chk("both_rsp1_valid", 32'(rsp1_valid), 32'(exp_r1));
         chk("both_rsp0_valid", 32'(rsp0_valid), 32'(!exp_r1));
         if (exp_r1) chk("both_rsp1_data", rsp1_data, 32'hA500_0004);
         else        chk("both_rsp0_data", rsp0_data, 32'hA500_0008);
      end
      chk("both_p0_grants", 32'(p0_grants), 32'd8);

      // port 0 goes idle after two cycles: port 1 granted immediately
      #1;
      chk("idle_c0_r1", 32'(req1_ready), 32'd0);
      tick();
      #1;
      chk("idle_c1_cnt", 32'(starve_cnt), 32'd1);
      chk("idle_c1_r1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      #1;
      chk("idle_c2_cnt", 32'(starve_cnt), 32'd2);
      chk("idle_c2_r1", 32'(req1_ready), 32'd1);
      tick();
      chk("idle_rsp1_valid", 32'(rsp1_valid), 32'd1);
      chk("idle_cnt_clear", 32'(starve_cnt), 32'd0);
      req1_valid = 1'b0;

      // asynchronous reset while port 0 is being granted
      req0_valid = 1'b1; req0_addr = 31'h8;
      req1_valid = 1'b1; req1_addr = 31'h10;
      tick();
      tick();
      chk("mid_pre_valid", 32'(rsp0_valid), 32'd1);
      chk("mid_pre_cnt", 32'(starve_cnt), 32'd2);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(rsp0_valid), 32'd0);
      chk("mid_rst_cnt", 32'(starve_cnt), 32'd0);
      chk("mid_rst_data", rsp0_data, 32'd0);
      tick();
      chk("mid_next_valid0", 32'(rsp0_valid), 32'd0);
      chk("mid_next_valid1", 32'(rsp1_valid), 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      reset = 1'b0;
      tick();
      chk("mid_after_valid", 32'(rsp0_valid), 32'd0);

      // misaligned and out-of-range addresses
      req0_valid = 1'b1; req0_addr = 31'h6;
      #1;
      chk("err0_ready", 32'(req0_ready), 32'd1);
      tick();
      chk("err0_valid", 32'(rsp0_valid), 32'd1);
`ifdef ROM_ALIGN_CHECK_EN
      chk("err0_err", 32'(rsp0_err), 32'd1);
      chk("err0_data", rsp0_data, 32'd0);
`else
      chk("err0_err", 32'(rsp0_err), 32'd0);
      chk("err0_data", rsp0_data, 32'hA500_0001);
`endif
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_addr = 31'h400;
      #1;
      chk("err1_ready", 32'(req1_ready), 32'd1);
      tick();
      chk("err1_valid", 32'(rsp1_valid), 32'd1);
`ifdef ROM_ALIGN_CHECK_EN
      chk("err1_err", 32'(rsp1_err), 32'd1);
`else
      chk("err1_err", 32'(rsp1_err), 32'd0);
`endif
      chk("err1_data", rsp1_data, 32'd0);
      req1_valid = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
